// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the IF/MEM single-port memory arbiter.
package mem_arb_pkg;
    typedef enum logic {IDLE, BUSY} state_t;
    typedef enum logic {OWN_IF, OWN_DM} owner_t;

    localparam int MEM_LAT_MAX = 15;
    localparam int LAT_CNT_W   = 4;

    // Out-of-range latencies are pulled into 1..MEM_LAT_MAX at elaboration.
    function automatic int clamp_lat(input int lat);
        if (lat < 1)
            return 1;
        else if (lat > MEM_LAT_MAX)
            return MEM_LAT_MAX;
        else
            return lat;
    endfunction
endpackage

// File: rtl/mem_arb_lat_cnt.sv
// Loadable latency up-counter; tc flags the last active cycle (count = LAT-1).
module mem_arb_lat_cnt
    import mem_arb_pkg::*;
#(
    parameter int LAT = 3
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic en,
    output logic tc
);
    localparam logic [LAT_CNT_W-1:0] TC_VAL = LAT_CNT_W'(LAT - 1);

    logic [LAT_CNT_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (reset)
            cnt <= '0;
        else if (clear)
            cnt <= '0;
        else if (en)
            cnt <= cnt + 1'b1;
    end

    assign tc = en & (cnt == TC_VAL);
endmodule

// File: rtl/mem_port_arbiter.sv
// Fixed-priority (DM over IF) arbiter for one single-port memory with pipeline stall control.
// Optional wait-cycle perf counters are built when MEM_PORT_ARB_PERF_EN is defined.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int MEM_LAT = 3,
    parameter int AW      = 32,
    parameter int DW      = 32
) (
    input  logic          Clk,
    input  logic          Reset,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic          if_gnt,
    output logic          if_done,
    output logic [DW-1:0] if_rdata,
    input  logic          dm_req,
    input  logic          dm_we,
    input  logic [AW-1:0] dm_addr,
    input  logic [DW-1:0] dm_wdata,
    output logic          dm_gnt,
    output logic          dm_done,
    output logic [DW-1:0] dm_rdata,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic          pc_write,
    output logic          if_id_write,
    output logic          pipe_stall,
    output logic [31:0]   perf_if_wait,
    output logic [31:0]   perf_dm_wait
);
    localparam int LAT = clamp_lat(MEM_LAT);

    state_t state, state_nxt;
    owner_t owner;
    logic   we_r;
    logic   grant;
    logic   busy;
    logic   last;
    logic   dm_busy, if_busy;

    always_ff @(posedge Clk) begin
        if (Reset)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // Grants are combinational in IDLE and suppressed while Reset is high.
    always_comb begin
        state_nxt = state;
        dm_gnt    = 1'b0;
        if_gnt    = 1'b0;
        case (state)
            IDLE: begin
                if (!Reset) begin
                    if (dm_req) begin
                        dm_gnt    = 1'b1;
                        state_nxt = BUSY;
                    end else if (if_req) begin
                        if_gnt    = 1'b1;
                        state_nxt = BUSY;
                    end
                end
            end
            BUSY:    if (last) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign grant = if_gnt | dm_gnt;
    assign busy  = (state == BUSY);

    mem_arb_lat_cnt #(.LAT(LAT)) u_lat_cnt (
        .clk   (Clk),
        .reset (Reset),
        .clear (grant),
        .en    (busy),
        .tc    (last)
    );

    always_ff @(posedge Clk) begin
        if (Reset) begin
            owner     <= OWN_IF;
            we_r      <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            if_rdata  <= '0;
            dm_rdata  <= '0;
            if_done   <= 1'b0;
            dm_done   <= 1'b0;
        end else begin
            if_done <= 1'b0;
            dm_done <= 1'b0;
            if (dm_gnt) begin
                owner     <= OWN_DM;
                we_r      <= dm_we;
                mem_addr  <= dm_addr;
                mem_wdata <= dm_wdata;
            end else if (if_gnt) begin
                owner     <= OWN_IF;
                we_r      <= 1'b0;
                mem_addr  <= if_addr;
            end
            // Stores leave dm_rdata untouched; they still get a done pulse.
            if (last) begin
                if (owner == OWN_DM) begin
                    dm_done <= 1'b1;
                    if (!we_r)
                        dm_rdata <= mem_rdata;
                end else begin
                    if_done  <= 1'b1;
                    if_rdata <= mem_rdata;
                end
            end
        end
    end

    assign mem_en = busy;
    assign mem_we = busy & we_r;

    assign dm_busy     = (dm_req & ~dm_gnt) | (busy & (owner == OWN_DM));
    assign if_busy     = (if_req & ~if_gnt) | (busy & (owner == OWN_IF));
    assign pipe_stall  = dm_busy;
    assign pc_write    = ~(dm_busy | if_busy);
    assign if_id_write = ~(dm_busy | if_busy);

`ifdef MEM_PORT_ARB_PERF_EN
    logic [31:0] if_wait_q, dm_wait_q;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            if_wait_q <= '0;
            dm_wait_q <= '0;
        end else begin
            if (if_req && !if_gnt && if_wait_q != 32'hFFFF_FFFF)
                if_wait_q <= if_wait_q + 32'd1;
            if (dm_req && !dm_gnt && dm_wait_q != 32'hFFFF_FFFF)
                dm_wait_q <= dm_wait_q + 32'd1;
        end
    end

    assign perf_if_wait = if_wait_q;
    assign perf_dm_wait = dm_wait_q;
`else
    assign perf_if_wait = 32'd0;
    assign perf_dm_wait = 32'd0;
`endif
endmodule
